// File: rtl/a_debounce.sv
// Debouncer for a bouncing mechanical key: two-flop synchronizer followed by a
// one-hot check FSM that accepts a level only after it has been stable long enough.
module a_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       key_in,
    output logic       A,
    output logic       rise,
    output logic       fall,
    output logic [7:0] bounce_cnt
);

    localparam logic [3:0] ST_LOW      = 4'b0001;
    localparam logic [3:0] ST_RISE_CHK = 4'b0010;
    localparam logic [3:0] ST_HIGH     = 4'b0100;
    localparam logic [3:0] ST_FALL_CHK = 4'b1000;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [7:0]       BNC_MAX  = 8'hFF;

    logic             sync1_q;
    logic             sync2_q;
    logic             key_s;

    logic [3:0]       state_q;
    logic [3:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             a_q;
    logic             a_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;
    logic [7:0]       bounce_q;
    logic [7:0]       bounce_d;
    logic             bounce_inc;

    // Only the first synchronizer flop ever looks at the asynchronous key.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    assign key_s = sync2_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        bounce_inc = 1'b0;

        case (state_q)
            ST_LOW: begin
                if (key_s) begin
                    state_d = ST_RISE_CHK;
                    cnt_d   = CNT_ZERO;
                end
            end

            ST_RISE_CHK: begin
                if (!key_s) begin
                    state_d    = ST_LOW;
                    cnt_d      = CNT_ZERO;
                    bounce_inc = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                    a_d     = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_HIGH: begin
                if (!key_s) begin
                    state_d = ST_FALL_CHK;
                    cnt_d   = CNT_ZERO;
                end
            end

            ST_FALL_CHK: begin
                if (key_s) begin
                    state_d    = ST_HIGH;
                    cnt_d      = CNT_ZERO;
                    bounce_inc = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                    a_d     = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            // Corrupted encodings recover to a known-quiet LOW without touching the bounce history.
            default: begin
                state_d = ST_LOW;
                cnt_d   = CNT_ZERO;
                a_d     = 1'b0;
            end
        endcase
    end

    always_comb begin
        bounce_d = bounce_q;
        if (bounce_inc && (bounce_q != BNC_MAX)) begin
            bounce_d = bounce_q + 8'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q  <= ST_LOW;
            cnt_q    <= CNT_ZERO;
            a_q      <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            bounce_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            bounce_q <= bounce_d;
        end
    end

    assign A          = a_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign bounce_cnt = bounce_q;

endmodule

// File: tb/tb_a_debounce.sv
// Directed plus randomized bench for a_debounce, checked every cycle against a
// run-length model of the accepted level.
module tb_a_debounce;

    localparam int DEB = 16;

    logic       Clock;
    logic       Reset;
    logic       key_in;
    logic       A;
    logic       rise;
    logic       fall;
    logic [7:0] bounce_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: synchronizer delay line plus a count of consecutive
    // synchronized samples that disagree with the accepted level.
    int m_s1, m_s2, m_a, m_run, m_bounce, m_rise, m_fall;

    a_debounce #(.DEBOUNCE_CYCLES(DEB), .CNT_W(8)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .key_in     (key_in),
        .A          (A),
        .rise       (rise),
        .fall       (fall),
        .bounce_cnt (bounce_cnt)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic k, input logic rst);
        int ks;
        key_in = k;
        Reset  = rst;
        @(posedge Clock);
        if (!rst) begin
            m_s1 = 0; m_s2 = 0; m_a = 0; m_run = 0;
            m_bounce = 0; m_rise = 0; m_fall = 0;
        end else begin
            ks   = m_s2;
            m_s2 = m_s1;
            m_s1 = int'(k);
            m_rise = 0;
            m_fall = 0;
            if (ks != m_a) begin
                m_run++;
                // The sample that opens the check plus DEB more stable samples.
                if (m_run == DEB + 1) begin
                    m_a = ks;
                    if (ks == 1) m_rise = 1; else m_fall = 1;
                    m_run = 0;
                end
            end else if (m_run > 0) begin
                if (m_bounce < 255) m_bounce++;
                m_run = 0;
            end
        end
        #1;
        check("A", int'(A), m_a);
        check("rise", int'(rise), m_rise);
        check("fall", int'(fall), m_fall);
        check("bounce_cnt", int'(bounce_cnt), m_bounce);
    endtask

    // Holds key at lvl and returns how many edges after the first one A reached lvl.
    task automatic measure(input logic lvl, output int lat, output int other_pulse);
        lat = -1;
        other_pulse = 0;
        for (int i = 0; i < 40; i++) begin
            step(lvl, 1'b1);
            if ((lvl && fall) || (!lvl && rise)) other_pulse = 1;
            if (int'(A) == int'(lvl)) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat, other, lvl, len;
        Reset  = 1'b0;
        key_in = 1'b0;

        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("reset_A", int'(A), 0);
        check("reset_bounce", int'(bounce_cnt), 0);
        $display("phase reset: A=%0d bounce=%0d", A, bounce_cnt);

        // Clean press and the pulse that follows.
        repeat (3) step(1'b0, 1'b1);
        measure(1'b1, lat, other);
        check("press_latency", lat, 18);
        check("press_rise", int'(rise), 1);
        step(1'b1, 1'b1);
        check("press_rise_end", int'(rise), 0);
        check("press_bounce", int'(bounce_cnt), 0);
        $display("phase clean_press: latency=%0d bounce=%0d", lat, bounce_cnt);

        // Release from HIGH.
        repeat (4) step(1'b1, 1'b1);
        measure(1'b0, lat, other);
        check("release_latency", lat, 18);
        check("release_fall", int'(fall), 1);
        check("release_no_rise", other, 0);
        $display("phase release: latency=%0d", lat);

        // Bouncy press.
        step(1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1);
        repeat (5) step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1);
        measure(1'b1, lat, other);
        check("bouncy_latency", lat, 18);
        check("bouncy_bounce", int'(bounce_cnt), 1);
        step(1'b1, 1'b1);
        check("bouncy_single_rise", int'(rise), 0);
        $display("phase bouncy_press: latency=%0d bounce=%0d", lat, bounce_cnt);

        // Single-cycle glitch while LOW.
        step(1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (25) step(1'b0, 1'b1);
        check("glitch_A", int'(A), 0);
        check("glitch_bounce", int'(bounce_cnt), 1);
        $display("phase glitch: A=%0d bounce=%0d", A, bounce_cnt);

        // Reset at cnt=10 of the rise check, then recovery.
        step(1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b1);
        repeat (13) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        check("midreset_A", int'(A), 0);
        check("midreset_rise", int'(rise), 0);
        check("midreset_bounce", int'(bounce_cnt), 0);
        measure(1'b1, lat, other);
        check("midreset_latency", lat, 18);
        $display("phase reset_mid_check: latency=%0d", lat);

        // Reset on the exact edge that would accept the press.
        step(1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b1);
        repeat (18) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        check("edge_reset_rise", int'(rise), 0);
        check("edge_reset_A", int'(A), 0);
        $display("phase reset_on_accept: A=%0d rise=%0d", A, rise);

        // Randomized bursts, occasionally interrupted by reset.
        for (int b = 0; b < 80; b++) begin
            lvl = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 24));
            for (int i = 0; i < len; i++) begin
                step(lvl[0], ($urandom_range(0, 150) == 0) ? 1'b0 : 1'b1);
            end
        end
        $display("phase random: A=%0d bounce=%0d", A, bounce_cnt);

        // Saturation from HIGH: 300 aborted fall checks.
        step(1'b1, 1'b0);
        measure(1'b1, lat, other);
        check("sat_prep_A", int'(A), 1);
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b1);
            step(1'b1, 1'b1);
            step(1'b1, 1'b1);
        end
        repeat (4) step(1'b1, 1'b1);
        check("sat_bounce", int'(bounce_cnt), 255);
        check("sat_A", int'(A), 1);
        $display("phase saturation: A=%0d bounce=%0d", A, bounce_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/a_debounce.md
A_DEBOUNCE -- requirements
Module: a_debounce

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 16, the number of consecutive stable synchronized samples required to accept a level change (legal range 2..255).
REQ-002 SHALL provide parameter CNT_W, default 8, the width of the stability counter (must hold DEBOUNCE_CYCLES-1).
REQ-003 SHALL have port Clock  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port Reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port key_in  input  1  raw asynchronous, bouncing switch level.
REQ-006 SHALL have port A  output  1  debounced level, feeds the control FSM input A.
REQ-007 SHALL have port rise  output  1  one-cycle pulse on accepted 0->1 change of A.
REQ-008 SHALL have port fall  output  1  one-cycle pulse on accepted 1->0 change of A.
REQ-009 SHALL have port bounce_cnt  output  8  saturating count of aborted change checks since reset.

Function
REQ-010 SHALL pass key_in through a two-flop synchronizer; second flop output is key_s; no other logic shall read key_in.
REQ-011 SHALL implement a one-hot state register: LOW=4'b0001, RISE_CHK=4'b0010, HIGH=4'b0100, FALL_CHK=4'b1000.
REQ-012 LOW: key_s=1 -> RISE_CHK, cnt<=0; key_s=0 -> stay LOW.
REQ-013 RISE_CHK: key_s=0 -> LOW, cnt<=0, bounce_cnt+1; key_s=1 and cnt==DEBOUNCE_CYCLES-1 -> HIGH, A<=1, rise<=1; key_s=1 otherwise -> cnt+1.
REQ-014 HIGH: key_s=0 -> FALL_CHK, cnt<=0; key_s=1 -> stay HIGH.
REQ-015 FALL_CHK: key_s=1 -> HIGH, cnt<=0, bounce_cnt+1; key_s=0 and cnt==DEBOUNCE_CYCLES-1 -> LOW, A<=0, fall<=1; key_s=0 otherwise -> cnt+1.
REQ-016 Any non-one-hot or all-zero state value SHALL go to LOW next cycle with A<=0, cnt<=0, rise/fall<=0, bounce_cnt unchanged.
REQ-017 A, rise, fall, bounce_cnt SHALL be registered outputs; no combinational path from key_in to any output.
REQ-018 Latency: key_in first sampled at new level on edge T and held -> A changes and rise/fall asserts after edge T+DEBOUNCE_CYCLES+2.
REQ-019 rise and fall SHALL each be high exactly one cycle per accepted change and never both high in the same cycle.
REQ-020 A SHALL change only in the cycle rise or fall asserts; A stays constant while in RISE_CHK or FALL_CHK.
REQ-021 bounce_cnt SHALL saturate at 8'hFF and not wrap.
REQ-022 A bounce during a check SHALL restart the full DEBOUNCE_CYCLES window on the next return to the new level.

Reset
REQ-023 When Reset=0 at a rising edge: sync flops<=0, state<=LOW, cnt<=0, A<=0, rise<=0, fall<=0, bounce_cnt<=0.
REQ-024 Reset SHALL override all transitions, including mid-check and the cycle a rise/fall would assert (no pulse emitted).
REQ-025 After reset release with key_in held high, A SHALL rise via the normal RISE_CHK path, latency per REQ-018 from first post-reset sample.

Verification
REQ-026 Clean press, DEBOUNCE_CYCLES=16: key_in 0->1 sampled at edge T, held -> A=1 and rise=1 after edge T+18, rise low after T+19, bounce_cnt=0.
REQ-027 Bouncy press: key_in high 5 cycles, low 3, then high steady -> bounce_cnt=1, A rises 18 cycles after the final high sample, single rise pulse.
REQ-028 Release: from HIGH, key_in 1->0 held -> A=0 and fall=1 after 18 edges; rise stays 0 throughout.
REQ-029 Glitch shorter than synchronizer plus window (1-cycle high pulse) while LOW -> A stays 0, no rise, bounce_cnt=1.
REQ-030 Reset asserted at cnt=10 of RISE_CHK with key_in high -> all outputs 0 next cycle; after release, A rises 18 cycles after first sample.
REQ-031 Saturation: 300 aborted checks -> bounce_cnt=8'hFF, A unchanged.
